// File: rtl/cu_pkg.sv
// Constants shared by the compute-unit multiplier, crossbar and program sequencer.
package cu_pkg;

  typedef enum logic [2:0] {
    MUL_OP_MUL   = 3'b000,
    MUL_OP_MAC   = 3'b001,
    MUL_OP_MSUB  = 3'b010,
    MUL_OP_MRCLR = 3'b011,
    MUL_OP_MRRD  = 3'b100
  } mul_op_e;

  localparam int MUL_LAT = 2;

  function automatic int mr_width(input int data_width, input int guard_width);
    return 2 * data_width + guard_width;
  endfunction

  function automatic logic mul_op_defined(input logic [2:0] op);
    return op <= MUL_OP_MRRD;
  endfunction

endpackage

// File: rtl/mul_result_fmt.sv
// Selects the integer/fractional field from an MR-wide value, saturates it and
// derives the overflow and negative flags.
module mul_result_fmt
  import cu_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int GUARD_WIDTH = 8,
  localparam int MRW = mr_width(DATA_WIDTH, GUARD_WIDTH)
) (
  input  logic [MRW-1:0]        v,
  input  logic                  frac,
  input  logic                  sat,
  input  logic [1:0]            sgn,
  output logic [DATA_WIDTH-1:0] dt,
  output logic                  mv,
  output logic                  mn
);

  logic signed [MRW-1:0] v_asr;
  logic [MRW-1:0]        v_sh;
  logic                  is_sgn;
  logic                  neg;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] lim;

  always_comb begin
    v_asr  = $signed(v) >>> DATA_WIDTH;
    v_sh   = frac ? v_asr : v;
    is_sgn = |sgn;
    neg    = v[MRW-1];
    // The selected field sits in the low W bits of v_sh; everything above it
    // must be pure sign (signed) or zero (unsigned) for the value to fit.
    if (is_sgn) begin
      in_range = (&v_sh[MRW-1:DATA_WIDTH-1]) | ~(|v_sh[MRW-1:DATA_WIDTH-1]);
      lim      = neg ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      in_range = ~(|v_sh[MRW-1:DATA_WIDTH]);
      lim      = neg ? '0 : '1;
    end
    dt = (sat && !in_range) ? lim : v_sh[DATA_WIDTH-1:0];
    mv = !in_range;
    mn = neg;
  end

endmodule

// File: rtl/cu_multiplier.sv
// Two-stage pipelined multiplier/accumulator: stage 1 forms the product from the
// captured operands, stage 2 updates the guarded MR accumulator and formats the result.
module cu_multiplier
  import cu_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int GUARD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ps_mul_en,
  input  logic [2:0]            ps_mul_op,
  input  logic [1:0]            ps_mul_sgn,
  input  logic                  ps_mul_frac,
  input  logic                  ps_mul_sat,
  input  logic [DATA_WIDTH-1:0] xb_mul_rx,
  input  logic [DATA_WIDTH-1:0] xb_mul_ry,
  output logic [DATA_WIDTH-1:0] mul_xb_dt,
  output logic                  mul_xb_vld,
  output logic                  mul_ps_mv,
  output logic                  mul_ps_mn,
  output logic                  mul_ps_mos
);

  localparam int W   = DATA_WIDTH;
  localparam int MRW = mr_width(DATA_WIDTH, GUARD_WIDTH);
  localparam int PW  = 2 * W + 2;

  logic          s1_vld;
  mul_op_e       s1_op;
  logic [1:0]    s1_sgn;
  logic          s1_frac;
  logic          s1_sat;
  logic [W-1:0]  s1_rx;
  logic [W-1:0]  s1_ry;

  logic          s2_vld;
  mul_op_e       s2_op;
  logic [1:0]    s2_sgn;
  logic          s2_frac;
  logic          s2_sat;
  logic [MRW-1:0] s2_p;

  logic [MRW-1:0] mr;

  logic [PW-1:0]  rx_wide;
  logic [PW-1:0]  ry_wide;
  logic [PW-1:0]  prod;
  logic [MRW-1:0] p_ext;
  logic [MRW-1:0] p_sh;

  logic [MRW-1:0] sum;
  logic [MRW-1:0] diff;
  logic [MRW-1:0] v;
  logic [MRW-1:0] mr_nxt;
  logic           wrap;

  logic [W-1:0]   fmt_dt;
  logic           fmt_mv;
  logic           fmt_mn;
  logic           mv_nxt;

  // Operands widened to the full product width so the low bits of the
  // product are exact two's complement regardless of signedness.
  always_comb begin
    rx_wide = {{(W + 2){s1_sgn[1] & s1_rx[W-1]}}, s1_rx};
    ry_wide = {{(W + 2){s1_sgn[0] & s1_ry[W-1]}}, s1_ry};
    prod    = rx_wide * ry_wide;
    p_ext   = {{(MRW - PW){prod[PW-1]}}, prod};
    p_sh    = s1_frac ? {p_ext[MRW-2:0], 1'b0} : p_ext;
  end

  always_comb begin
    sum    = mr + s2_p;
    diff   = mr - s2_p;
    v      = s2_p;
    mr_nxt = mr;
    wrap   = 1'b0;
    unique case (s2_op)
      MUL_OP_MAC: begin
        mr_nxt = sum;
        v      = sum;
        wrap   = (mr[MRW-1] == s2_p[MRW-1]) && (sum[MRW-1] != mr[MRW-1]);
      end
      MUL_OP_MSUB: begin
        mr_nxt = diff;
        v      = diff;
        wrap   = (mr[MRW-1] != s2_p[MRW-1]) && (diff[MRW-1] != mr[MRW-1]);
      end
      MUL_OP_MRCLR: begin
        mr_nxt = '0;
        v      = '0;
      end
      MUL_OP_MRRD: v = mr;
      default:     v = s2_p;
    endcase
    mv_nxt = fmt_mv | wrap;
  end

  mul_result_fmt #(
    .DATA_WIDTH (DATA_WIDTH),
    .GUARD_WIDTH(GUARD_WIDTH)
  ) u_fmt (
    .v   (v),
    .frac(s2_frac),
    .sat (s2_sat),
    .sgn (s2_sgn),
    .dt  (fmt_dt),
    .mv  (fmt_mv),
    .mn  (fmt_mn)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld     <= 1'b0;
      s1_op      <= MUL_OP_MUL;
      s1_sgn     <= '0;
      s1_frac    <= 1'b0;
      s1_sat     <= 1'b0;
      s1_rx      <= '0;
      s1_ry      <= '0;
      s2_vld     <= 1'b0;
      s2_op      <= MUL_OP_MUL;
      s2_sgn     <= '0;
      s2_frac    <= 1'b0;
      s2_sat     <= 1'b0;
      s2_p       <= '0;
      mr         <= '0;
      mul_xb_dt  <= '0;
      mul_xb_vld <= 1'b0;
      mul_ps_mv  <= 1'b0;
      mul_ps_mn  <= 1'b0;
      mul_ps_mos <= 1'b0;
    end else begin
      s1_vld <= ps_mul_en && mul_op_defined(ps_mul_op);
      if (ps_mul_en && mul_op_defined(ps_mul_op)) begin
        s1_op   <= mul_op_e'(ps_mul_op);
        s1_sgn  <= ps_mul_sgn;
        s1_frac <= ps_mul_frac;
        s1_sat  <= ps_mul_sat;
        s1_rx   <= xb_mul_rx;
        s1_ry   <= xb_mul_ry;
      end

      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_op   <= s1_op;
        s2_sgn  <= s1_sgn;
        s2_frac <= s1_frac;
        s2_sat  <= s1_sat;
        s2_p    <= p_sh;
      end

      if (s2_vld) begin
        mr         <= mr_nxt;
        mul_xb_dt  <= fmt_dt;
        mul_xb_vld <= 1'b1;
        mul_ps_mv  <= mv_nxt;
        mul_ps_mn  <= fmt_mn;
        mul_ps_mos <= (s2_op == MUL_OP_MRCLR) ? 1'b0 : (mul_ps_mos | mv_nxt);
      end else begin
        mul_xb_vld <= 1'b0;
        mul_ps_mv  <= 1'b0;
        mul_ps_mn  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cu_multiplier.sv
// Directed bench for cu_multiplier: isolated ops from a vector table, then
// back-to-back accumulation and reset-during-flight sequences.
module tb_cu_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps_mul_en;
  logic [2:0]  ps_mul_op;
  logic [1:0]  ps_mul_sgn;
  logic        ps_mul_frac;
  logic        ps_mul_sat;
  logic [15:0] xb_mul_rx;
  logic [15:0] xb_mul_ry;
  logic [15:0] mul_xb_dt;
  logic        mul_xb_vld;
  logic        mul_ps_mv;
  logic        mul_ps_mn;
  logic        mul_ps_mos;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cu_multiplier #(.DATA_WIDTH(16), .GUARD_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps_mul_en  (ps_mul_en),
    .ps_mul_op  (ps_mul_op),
    .ps_mul_sgn (ps_mul_sgn),
    .ps_mul_frac(ps_mul_frac),
    .ps_mul_sat (ps_mul_sat),
    .xb_mul_rx  (xb_mul_rx),
    .xb_mul_ry  (xb_mul_ry),
    .mul_xb_dt  (mul_xb_dt),
    .mul_xb_vld (mul_xb_vld),
    .mul_ps_mv  (mul_ps_mv),
    .mul_ps_mn  (mul_ps_mn),
    .mul_ps_mos (mul_ps_mos)
  );

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  sgn;
    logic        frac;
    logic        sat;
    logic [15:0] rx;
    logic [15:0] ry;
    logic [15:0] dt;
    logic        vld;
    logic        mv;
    logic        mn;
    logic        mos;
  } vec_t;

  vec_t vecs[14];
  vec_t seq_a[6];

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] sgn,
                              input logic frac, input logic sat,
                              input logic [15:0] rx, input logic [15:0] ry,
                              input logic [15:0] dt, input logic vld,
                              input logic mv, input logic mn, input logic mos);
    vec_t r;
    r.op = op; r.sgn = sgn; r.frac = frac; r.sat = sat; r.rx = rx; r.ry = ry;
    r.dt = dt; r.vld = vld; r.mv = mv; r.mn = mn; r.mos = mos;
    return r;
  endfunction

  task automatic drive(input logic en, input vec_t x);
    ps_mul_en   = en;
    ps_mul_op   = x.op;
    ps_mul_sgn  = x.sgn;
    ps_mul_frac = x.frac;
    ps_mul_sat  = x.sat;
    xb_mul_rx   = x.rx;
    xb_mul_ry   = x.ry;
  endtask

  task automatic idle();
    ps_mul_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] dt, input logic vld,
                       input logic mv, input logic mn, input logic mos);
    total++;
    if ({mul_xb_dt, mul_xb_vld, mul_ps_mv, mul_ps_mn, mul_ps_mos} !== {dt, vld, mv, mn, mos}) begin
      bad++;
      $display("FAIL %s: got dt=%h vld=%b mv=%b mn=%b mos=%b, want dt=%h vld=%b mv=%b mn=%b mos=%b",
               name, mul_xb_dt, mul_xb_vld, mul_ps_mv, mul_ps_mn, mul_ps_mos,
               dt, vld, mv, mn, mos);
    end
  endtask

  // Issue one op, then sample two edges after the edge that captured it.
  task automatic run_one(input string name, input vec_t x);
    drive(1'b1, x);
    step();
    idle();
    step();
    step();
    check(name, x.dt, x.vld, x.mv, x.mn, x.mos);
  endtask

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_MAC   = 3'b001;
  localparam logic [2:0] OP_MSUB  = 3'b010;
  localparam logic [2:0] OP_MRCLR = 3'b011;
  localparam logic [2:0] OP_MRRD  = 3'b100;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  initial begin
    //          op        sgn    fr    sat   rx        ry        dt        vld   mv    mn    mos
    vecs[0]  = mk(OP_MUL,   2'b11, 1'b0, 1'b0, 16'h0003, 16'hFFFE, 16'hFFFA, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[1]  = mk(OP_MUL,   2'b11, 1'b1, 1'b0, 16'h4000, 16'h4000, 16'h2000, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(OP_MUL,   2'b11, 1'b1, 1'b1, 16'h8000, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);
    vecs[3]  = mk(OP_MRCLR, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(OP_MUL,   2'b00, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1);
    vecs[5]  = mk(OP_MUL,   2'b00, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    vecs[6]  = mk(OP_MRCLR, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(OP_MSUB,  2'b11, 1'b0, 1'b0, 16'h0002, 16'h0003, 16'hFFFA, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[8]  = mk(OP_RSVD,  2'b11, 1'b0, 1'b0, 16'h1234, 16'h5678, 16'hFFFA, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(OP_MRRD,  2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFA, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[10] = mk(OP_MRRD,  2'b11, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[11] = mk(OP_MAC,   2'b11, 1'b0, 1'b0, 16'h0007, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk(OP_MRCLR, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[13] = mk(OP_MAC,   2'b10, 1'b0, 1'b0, 16'hFFFF, 16'h0002, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0);

    // MR = -2 entering this sequence
    seq_a[0] = mk(OP_MAC,   2'b11, 1'b0, 1'b0, 16'h0005, 16'h0005, 16'h0017, 1'b1, 1'b0, 1'b0, 1'b0);
    seq_a[1] = mk(OP_MRCLR, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    seq_a[2] = mk(OP_MAC,   2'b11, 1'b0, 1'b0, 16'd100,  16'd200,  16'h4E20, 1'b1, 1'b0, 1'b0, 1'b0);
    seq_a[3] = mk(OP_MAC,   2'b11, 1'b0, 1'b0, 16'd100,  16'd200,  16'h9C40, 1'b1, 1'b1, 1'b0, 1'b1);
    seq_a[4] = mk(OP_MRRD,  2'b11, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);
    seq_a[5] = mk(OP_MRCLR, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

    reset = 1'b1;
    drive(1'b0, vecs[0]);
    step();
    step();
    step();
    check("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back issue: op j is driven in iteration j and checked in iteration j+3.
    for (int j = 0; j < 10; j++) begin
      if (j >= 3) begin
        if (j - 3 < 6)
          check($sformatf("b2b%0d", j - 3), seq_a[j-3].dt, seq_a[j-3].vld,
                seq_a[j-3].mv, seq_a[j-3].mn, seq_a[j-3].mos);
        else
          check("b2b_bubble", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      if (j < 6) drive(1'b1, seq_a[j]);
      else       idle();
      step();
    end

    run_one("pre_rst_ovf", mk(OP_MUL, 2'b00, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF,
                              16'h0001, 1'b1, 1'b1, 1'b0, 1'b1));
    run_one("pre_rst_mac", mk(OP_MAC, 2'b11, 1'b0, 1'b0, 16'h0003, 16'h0003,
                              16'h0009, 1'b1, 1'b0, 1'b0, 1'b1));

    // MAC in flight, then reset together with a second MAC issue.
    drive(1'b1, mk(OP_MAC, 2'b11, 1'b0, 1'b0, 16'h0004, 16'h0004,
                   16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    reset = 1'b1;
    drive(1'b1, mk(OP_MAC, 2'b11, 1'b0, 1'b0, 16'h0005, 16'h0005,
                   16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    check("rst_clears", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle();
    step();
    check("rst_drop_inflight", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("rst_drop_same_edge", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    run_one("post_rst_mrrd", mk(OP_MRRD, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000,
                                16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
